manch_tx_sched: RTL and testbench

MANCH_TX_SCHED -- requirements
Module: manch_tx_sched

---
 rtl/manch_tx_sched.sv | 149 ++++++++++++++
 tb/tb_manch_tx_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/manch_tx_sched.sv
// Two-requester Manchester frame transmitter with a round-robin arbiter.
// Each frame is: alternating preamble, source index, data byte LSB first, even parity, then a two-bit gap.
module manch_tx_sched #(
    parameter int BAUDRATE      = 230400,
    parameter int CLK_FREQ      = 18_750_000,
    parameter int PREAMBLE_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       tx_data,
    output logic       tx_manch,
    output logic       busy,
    output logic       frame_done
);
    localparam int HALFBIT  = CLK_FREQ / BAUDRATE;
    localparam int MAX_BITS = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
    localparam int TW       = (HALFBIT > 2) ? $clog2(HALFBIT) : 1;
    localparam int CW       = $clog2(MAX_BITS);

    if (HALFBIT < 2) begin : g_bad_halfbit
        $error("manch_tx_sched: CLK_FREQ/BAUDRATE must be at least 2");
    end
    if (PREAMBLE_BITS < 2 || PREAMBLE_BITS > 32) begin : g_bad_preamble
        $error("manch_tx_sched: PREAMBLE_BITS must be in 2..32");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SRC, S_DATA, S_PARITY, S_GAP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_timer;
    logic            r_phase;
    logic [CW-1:0]   r_cnt;
    logic            r_last_grant;
    logic [7:0]      r_data;
    logic            r_src;

    logic            w_grant_vld;
    logic            w_grant_idx;
    logic            w_accept;
    logic            w_half_end;
    logic            w_bit_end;
    logic            w_last_bit;
    logic            w_encoding;

    // Round-robin: on a tie the requester that did not win last time is granted.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_idx = ~r_last_grant;
        end else if (req0_valid) begin
            w_grant_vld = 1'b1;
        end else if (req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_idx = 1'b1;
        end
    end

    // Gating with rst keeps ready low while the state register is held in reset.
    assign w_accept   = (r_state == S_IDLE) && w_grant_vld && !rst;
    assign w_half_end = (r_timer == TW'(HALFBIT - 1));
    assign w_bit_end  = w_half_end && r_phase;

    always_comb begin
        w_last_bit = 1'b0;
        unique case (r_state)
            S_PREAMBLE: w_last_bit = (r_cnt == CW'(PREAMBLE_BITS - 1));
            S_SRC:      w_last_bit = 1'b1;
            S_DATA:     w_last_bit = (r_cnt == CW'(7));
            S_PARITY:   w_last_bit = 1'b1;
            S_GAP:      w_last_bit = (r_cnt == CW'(1));
            default:    w_last_bit = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (w_accept) w_next = S_PREAMBLE;
            S_PREAMBLE: if (w_bit_end && w_last_bit) w_next = S_SRC;
            S_SRC:      if (w_bit_end) w_next = S_DATA;
            S_DATA:     if (w_bit_end && w_last_bit) w_next = S_PARITY;
            S_PARITY:   if (w_bit_end) w_next = S_GAP;
            S_GAP:      if (w_bit_end && w_last_bit) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer      <= '0;
            r_phase      <= 1'b0;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_data       <= '0;
            r_src        <= 1'b0;
        end else if (w_accept) begin
            r_timer      <= '0;
            r_phase      <= 1'b0;
            r_cnt        <= '0;
            r_last_grant <= w_grant_idx;
            r_data       <= w_grant_idx ? req1_data : req0_data;
            r_src        <= w_grant_idx;
        end else if (r_state != S_IDLE) begin
            if (w_half_end) begin
                r_timer <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            // The counter restarts at every state change, so it never wraps inside a state.
            if (w_bit_end) r_cnt <= w_last_bit ? '0 : r_cnt + 1'b1;
        end
    end

    always_comb begin
        req0_ready = w_accept && !w_grant_idx;
        req1_ready = w_accept &&  w_grant_idx;
        busy       = (r_state != S_IDLE);
        frame_done = (r_state == S_GAP) && w_bit_end && w_last_bit;
        w_encoding = 1'b1;
        tx_data    = 1'b0;
        unique case (r_state)
            S_PREAMBLE: tx_data = ~r_cnt[0];
            S_SRC:      tx_data = r_src;
            S_DATA:     tx_data = r_data[r_cnt[2:0]];
            S_PARITY:   tx_data = ^{r_src, r_data};
            default:    w_encoding = 1'b0;
        endcase
        tx_manch = w_encoding && (tx_data ^ r_phase);
    end
endmodule

// File: tb/tb_manch_tx_sched.sv
// Directed bench: a small instance (HALFBIT=4, 2 preamble bits) for protocol checks and a default instance for timing.
module tb_manch_tx_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       s_v0, s_v1, s_r0, s_r1, s_txd, s_txm, s_busy, s_fd;
    logic [7:0] s_d0, s_d1;
    logic       d_v0, d_v1, d_r0, d_r1, d_txd, d_txm, d_busy, d_fd;
    logic [7:0] d_d0, d_d1;

    int n_checks = 0;
    int n_errors = 0;

    manch_tx_sched #(.BAUDRATE(2), .CLK_FREQ(8), .PREAMBLE_BITS(2)) u_small (
        .clk(clk), .rst(rst),
        .req0_valid(s_v0), .req0_data(s_d0), .req1_valid(s_v1), .req1_data(s_d1),
        .req0_ready(s_r0), .req1_ready(s_r1), .tx_data(s_txd), .tx_manch(s_txm),
        .busy(s_busy), .frame_done(s_fd)
    );

    manch_tx_sched u_dflt (
        .clk(clk), .rst(rst),
        .req0_valid(d_v0), .req0_data(d_d0), .req1_valid(d_v1), .req1_data(d_d1),
        .req0_ready(d_r0), .req1_ready(d_r1), .tx_data(d_txd), .tx_manch(d_txm),
        .busy(d_busy), .frame_done(d_fd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample point sits 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [5:0] s_outs();
        return {s_r0, s_r1, s_txd, s_txm, s_busy, s_fd};
    endfunction

    // Called in the accept cycle; follows the 14 bit times of a small-instance frame.
    task automatic watch_small(input string tag, input logic [0:11] bits,
                               input logic [1:0] keep_valid, input int raise1_at,
                               input logic [7:0] d0_after, input logic [7:0] d1_after);
        logic [7:0] pat_m, pat_d;
        int cyc;
        int fd_at, fd_cnt, rdy_cnt, nbusy;
        fd_at = -1; fd_cnt = 0; rdy_cnt = 0; nbusy = 0;
        for (int b = 0; b < 14; b++) begin
            pat_m = '0;
            pat_d = '0;
            for (int c = 0; c < 8; c++) begin
                tick();
                cyc = b * 8 + c + 1;
                if (cyc == 1) begin
                    s_v0 = s_v0 & keep_valid[0];
                    s_v1 = s_v1 & keep_valid[1];
                    s_d0 = d0_after;
                    s_d1 = d1_after;
                    settle();
                end
                if (cyc == raise1_at) begin
                    s_v1 = 1'b1;
                    settle();
                end
                pat_m = {pat_m[6:0], s_txm};
                pat_d = {pat_d[6:0], s_txd};
                if (s_fd) begin
                    fd_cnt++;
                    fd_at = cyc;
                end
                if (s_r0 || s_r1) rdy_cnt++;
                if (!s_busy) nbusy++;
            end
            if (b < 12) begin
                check($sformatf("%s bit%0d manch", tag, b), 32'(pat_m), bits[b] ? 32'hF0 : 32'h0F);
                check($sformatf("%s bit%0d data", tag, b), 32'(pat_d), bits[b] ? 32'hFF : 32'h00);
            end else begin
                check($sformatf("%s gap%0d line", tag, b - 12), 32'({pat_m, pat_d}), 32'h0);
            end
        end
        check({tag, " frame_done count"}, 32'(fd_cnt), 32'd1);
        check({tag, " frame_done cycle"}, 32'(fd_at), 32'd112);
        check({tag, " ready during frame"}, 32'(rdy_cnt), 32'd0);
        check({tag, " busy low during frame"}, 32'(nbusy), 32'd0);
    endtask

    initial begin
        int mism, fd_at, fd_cnt, first_fall, par_bit, bi;
        logic ph, exp_m;
        logic [0:19] dbits;

        rst = 1'b1;
        s_v0 = 1'b1; s_v1 = 1'b0; s_d0 = 8'hA5; s_d1 = 8'h00;
        d_v0 = 1'b0; d_v1 = 1'b0; d_d0 = 8'h00; d_d1 = 8'h00;
        tick();
        check("reset outputs small", 32'(s_outs()), 32'h0);
        check("reset outputs dflt", 32'({d_r0, d_r1, d_txd, d_txm, d_busy, d_fd}), 32'h0);
        s_v1 = 1'b1;
        tick();
        check("reset ready both valid", 32'({s_r0, s_r1}), 32'h0);
        s_v1 = 1'b0;
        tick();
        rst = 1'b0;
        settle();

        // Single request 0xA5 from req0
        check("A5 accept", 32'({s_r1, s_r0}), 32'b01);
        watch_small("A5", 12'b100_10100101_0, 2'b00, 0, 8'h00, 8'h00);
        tick();
        check("A5 idle after", 32'(s_outs()), 32'h0);

        // One-cycle valid pulse; data changed after the accepting edge
        s_v1 = 1'b1; s_d1 = 8'h3C;
        settle();
        check("3C accept req1", 32'({s_r1, s_r0}), 32'b10);
        watch_small("3C", 12'b101_00111100_1, 2'b00, 0, 8'h00, 8'hFF);
        tick();

        // req1 arrives mid-frame and must wait for the IDLE cycle after frame_done
        s_v0 = 1'b1; s_d0 = 8'h81;
        settle();
        check("81 accept req0", 32'({s_r1, s_r0}), 32'b01);
        watch_small("81", 12'b100_10000001_0, 2'b00, 40, 8'h81, 8'h7E);
        tick();
        check("7E ready after done", 32'({s_r1, s_r0}), 32'b10);
        check("7E idle at accept", 32'(s_busy), 32'd0);
        watch_small("7E", 12'b101_01111110_1, 2'b00, 0, 8'h81, 8'h7E);
        tick();
        check("7E idle after", 32'(s_outs()), 32'h0);

        // Both valid continuously: grants alternate 0,1,0,1
        s_d0 = 8'h01; s_d1 = 8'h02; s_v0 = 1'b1; s_v1 = 1'b1;
        settle();
        for (int f = 0; f < 4; f++) begin
            if (f > 0) tick();
            check($sformatf("rr grant%0d", f), 32'({s_r1, s_r0}), (f % 2 == 0) ? 32'b01 : 32'b10);
            if (f % 2 == 0)
                watch_small($sformatf("rr%0d", f), 12'b100_10000000_1, (f == 3) ? 2'b00 : 2'b11, 0, 8'h01, 8'h02);
            else
                watch_small($sformatf("rr%0d", f), 12'b101_01000000_0, (f == 3) ? 2'b00 : 2'b11, 0, 8'h01, 8'h02);
        end
        tick();
        check("rr idle after", 32'(s_outs()), 32'h0);

        // Reset during data bit 3 of a req0 frame
        s_v0 = 1'b1; s_d0 = 8'hFF;
        settle();
        check("abort accept", 32'({s_r1, s_r0}), 32'b01);
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (c == 1) begin
                s_v0 = 1'b0;
                settle();
            end
        end
        check("abort pre-reset line", 32'({s_busy, s_txd, s_txm}), 32'b111);
        rst = 1'b1;
        settle();
        check("abort outputs same cycle", 32'(s_outs()), 32'h0);
        s_v0 = 1'b1; s_v1 = 1'b1; s_d0 = 8'h33; s_d1 = 8'hCC;
        mism = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (s_outs() != 6'h0) mism++;
        end
        check("abort outputs held", 32'(mism), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        check("post-reset tie to req0", 32'({s_r1, s_r0}), 32'b01);
        watch_small("33", 12'b100_11001100_0, 2'b00, 0, 8'h33, 8'hCC);
        tick();
        check("33 idle after", 32'(s_outs()), 32'h0);

        // Default parameters: HALFBIT=81, PREAMBLE_BITS=8, byte 0xFF
        dbits = 20'b10101010_0_11111111_0_00;
        d_v0 = 1'b1; d_d0 = 8'hFF;
        settle();
        check("dflt accept", 32'({d_r1, d_r0}), 32'b01);
        mism = 0; fd_at = -1; fd_cnt = 0; first_fall = -1; par_bit = -1;
        for (int c = 1; c <= 3241; c++) begin
            tick();
            if (c == 1) begin
                d_v0 = 1'b0;
                settle();
            end
            bi = (c - 1) / 162;
            ph = (((c - 1) % 162) >= 81);
            exp_m = (c <= 3240 && bi < 18) ? (dbits[bi] ^ ph) : 1'b0;
            if (d_txm !== exp_m) mism++;
            if (c <= 3240 && !d_busy) mism++;
            if (d_fd) begin
                fd_cnt++;
                fd_at = c;
            end
            if (first_fall < 0 && !d_txm) first_fall = c;
            if (c == 17 * 162 + 41) par_bit = int'(d_txd);
        end
        check("dflt first half-bit end", 32'(first_fall), 32'd82);
        check("dflt parity bit", 32'(par_bit), 32'd0);
        check("dflt waveform mismatches", 32'(mism), 32'd0);
        check("dflt frame_done count", 32'(fd_cnt), 32'd1);
        check("dflt frame_done cycle", 32'(fd_at), 32'd3240);
        check("dflt idle after", 32'(d_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
